// File: rtl/seq_divider.sv
// seq_divider: sequential 32-bit radix-2 restoring divider.
// Accepts a dividend/divisor pair on start, retires one quotient bit per clock
// for 32 cycles, then a FIX cycle applies signs and registers the result with
// a one-cycle valid pulse. Latency from accepted start to valid is 34 cycles.
// Optional feature: define DIV_SIGNED_EN for signed two's-complement operands;
// the default build divides unsigned operands.
module seq_divider (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dvdnd,
    input  logic [31:0] dvsor,
    output logic [31:0] quot,
    output logic [31:0] remd,
    output logic        valid,
    output logic        div_zero,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    // Dividend bits shift out of the top while quotient bits shift in below.
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dz_q, dz_d;

    logic [31:0] quot_d, remd_d;
    logic        valid_d, div_zero_d;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_sh;
    logic [33:0] trial;
    logic [31:0] q_fix, r_fix;

    // Operand magnitudes and signs presented at capture time.
    always_comb begin
`ifdef DIV_SIGNED_EN
        a_neg = dvdnd[31];
        b_neg = dvsor[31];
`else
        a_neg = 1'b0;
        b_neg = 1'b0;
`endif
        a_mag = a_neg ? (~dvdnd + 32'd1) : dvdnd;
        b_mag = b_neg ? (~dvsor + 32'd1) : dvsor;
    end

    // One restoring step: shift {rem, dividend} left and trial-subtract.
    // An extra top bit keeps the sign of the trial unambiguous.
    assign rem_sh = {rem_q[31:0], dvd_q[31]};
    assign trial  = {1'b0, rem_sh} - {2'b00, dvs_q};

    // Sign correction applied in FIX; a zero divisor forces an all-ones quotient,
    // and re-signing the remainder magnitude restores the original dividend.
    always_comb begin
`ifdef DIV_SIGNED_EN
        q_fix = q_neg_q ? (~dvd_q + 32'd1) : dvd_q;
        r_fix = r_neg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
`else
        q_fix = dvd_q;
        r_fix = rem_q[31:0];
`endif
        if (dz_q) begin
            q_fix = 32'hFFFF_FFFF;
        end
    end

    assign busy = (state_q != StIdle);

    // Next-state logic for the control FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == 6'd31) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath and output next-state, driven by the current FSM state.
    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dz_d       = dz_q;
        quot_d     = quot;
        remd_d     = remd;
        div_zero_d = div_zero;
        valid_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dvd_d   = a_mag;
                    dvs_d   = b_mag;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    dz_d    = (dvsor == 32'd0);
                    rem_d   = 33'd0;
                    cnt_d   = 6'd0;
                end
            end
            StCalc: begin
                cnt_d = cnt_q + 6'd1;
                if (!trial[33]) begin
                    rem_d = trial[32:0];
                    dvd_d = {dvd_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    dvd_d = {dvd_q[30:0], 1'b0};
                end
            end
            StFix: begin
                quot_d     = q_fix;
                remd_d     = r_fix;
                div_zero_d = dz_q;
                valid_d    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers; reset discards any partial result.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q    <= 6'd0;
            rem_q    <= 33'd0;
            dvd_q    <= 32'd0;
            dvs_q    <= 32'd0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            quot     <= 32'd0;
            remd     <= 32'd0;
            valid    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            dz_q     <= dz_d;
            quot     <= quot_d;
            remd     <= remd_d;
            valid    <= valid_d;
            div_zero <= div_zero_d;
        end
    end

endmodule
